enemy_slot_scheduler: RTL and testbench
=======================================

// Module: enemy_slot_scheduler
// PURPOSE
//  Owns the fixed table of on-screen obstacle slots that feeds the game-data bus
//  read by the renderer. It services spawn requests from the enemy-generation
//  check, allocating the lowest free slot, and on every game tick scrolls all
//  live slots left by `speed`, freeing those that leave the screen.
//  Sits between the generation check / frequency divider and the VGA draw path.
// PARAMETERS
//  SLOTS     4    number of obstacle slots (2..8)
//  TYPEW     2    object type field width
//  XW        10   x-position width (left edge, pixels)
//  YW        9    y-position width
//  WW        7    object width field
//  HW        7    object height field
//  SCREEN_W  640  spawn x; must fit in XW bits
// PORTS
//  clock     in   1            system clock
//  rst       in   1            asynchronous reset, active-low
//  clear     in   1            synchronous game restart
//  tick      in   1            one-cycle game-step pulse, already synchronous to clock
//  speed     in   4            pixels moved per tick
//  gen_req   in   1            spawn request; held high until gen_ack
//  gen_type  in   TYPEW        type of object to spawn
//  gen_y     in   YW           y of object to spawn
//  gen_w     in   WW           width of object to spawn
//  gen_h     in   HW           height of object to spawn
//  gen_ack   out  1            one-cycle request completion (spawned or dropped)
//  busy      out  1            high whenever the FSM is not IDLE
//  slot_valid out SLOTS        per-slot live flag
//  slot_data out  SLOTS*F      F=TYPEW+XW+YW+WW+HW; per slot {type,x,y,w,h}; slot0 in LSBs
//  drop_cnt  out  8            saturating count of requests dropped because the table was full
// BEHAVIOUR
//  - rst low: all outputs and registers are 0 immediately (slot_valid, slot_data,
//    gen_ack, busy, drop_cnt, tick_pend). The FSM goes to IDLE. This applies mid-scan too.
//  - clear (1 cycle): at the next edge all slots are invalid, tick_pend=0,
//    drop_cnt=0, gen_ack=0 and the FSM is in IDLE. clear has priority over all other inputs.
//  - FSM states: IDLE, SCAN, ALLOC. All outputs are registered.
//  - tick_pend: set by a tick seen in any state. Cleared when SCAN is entered.
//    Extra ticks while tick_pend is set merge into one, so they are lost.
//  - IDLE transitions:
//      tick or tick_pend       -> SCAN, idx=0 (tick has priority)
//      gen_req && !gen_ack     -> ALLOC
//      otherwise               -> stay in IDLE
//  - SCAN: one slot per cycle, idx = 0..SLOTS-1.
//      valid slot, x <  speed  -> valid cleared (despawn)
//      valid slot, x >= speed  -> x <= x - speed
//      invalid slot            -> untouched
//    After idx = SLOTS-1: go to ALLOC if gen_req && !gen_ack, else IDLE.
//    Scan latency: tick in IDLE at cycle T, slot i updated at the edge ending
//    cycle T+1+i, FSM back to IDLE or ALLOC at T+1+SLOTS.
//  - ALLOC (1 cycle): a priority encoder picks the lowest-index invalid slot.
//      free slot found -> slot <= {gen_type, SCREEN_W, gen_y, gen_w, gen_h},
//                         valid set
//      table full      -> no slot written; drop_cnt increments, saturating at 255
//    gen_ack is high during the cycle after ALLOC in both cases. The FSM then
//    returns to IDLE.
//  - gen_req is ignored while gen_ack is high. The requester deasserts gen_req
//    in the cycle gen_ack is seen.
//  - A spawned object is never moved by the tick that was serviced before its ALLOC.
//  - speed=0: scan still runs and positions do not change; nothing despawns.
//  - x arithmetic is unsigned XW-bit and never wraps, because of the x < speed
//    despawn rule.
// TESTING
//  1. Reset mid-SCAN (rst low at scan cycle 2):
//     -> slot_valid=0, busy=0, gen_ack=0, drop_cnt=0 in the same cycle.
//  2. Spawn into an empty table (gen_req, type=2, y=300, w=20, h=40, FSM in IDLE):
//     -> slot0 = {2, 640, 300, 20, 40}, valid; gen_ack one cycle, 2 cycles after req.
//     -> a second request fills slot1.
//  3. Scroll (slot0 x=640, speed=5, tick):
//     -> busy high for 4 cycles (SLOTS=4); slot0 x=635; idle slots unchanged.
//  4. Despawn and reuse (slot0 x=3, speed=5, tick):
//     -> slot_valid[0]=0.
//     -> the next gen_req reuses slot0 even though slot1 is valid.
//  5. Full table (4 valid slots, gen_req):
//     -> gen_ack pulses, drop_cnt goes 0->1, slots unchanged.
//     -> 300 rejected requests leave drop_cnt=255.
//  6. tick and gen_req rise together in IDLE:
//     -> SCAN runs first, then ALLOC; the new object has x=640.
//     -> a tick arriving during that ALLOC runs exactly one more scan.

Source files
------------

// File: rtl/enemy_slot_scheduler.sv
// Fixed table of on-screen obstacle slots: allocates the lowest free slot on spawn requests
// and scrolls every live slot left by `speed` on each game tick, freeing those that exit.
module enemy_slot_scheduler #(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned TYPEW    = 2,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9,
  parameter int unsigned WW       = 7,
  parameter int unsigned HW       = 7,
  parameter int unsigned SCREEN_W = 640,
  localparam int unsigned F       = TYPEW + XW + YW + WW + HW,
  localparam int unsigned IW      = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic               clear,
  input  logic               tick,
  input  logic [3:0]         speed,
  input  logic               gen_req,
  input  logic [TYPEW-1:0]   gen_type,
  input  logic [YW-1:0]      gen_y,
  input  logic [WW-1:0]      gen_w,
  input  logic [HW-1:0]      gen_h,
  output logic               gen_ack,
  output logic               busy,
  output logic [SLOTS-1:0]   slot_valid,
  output logic [SLOTS*F-1:0] slot_data,
  output logic [7:0]         drop_cnt
);

  typedef enum logic [1:0] {StIdle, StScan, StAlloc} state_e;

  state_e           state_q;
  logic [IW-1:0]    idx_q;
  logic             tick_pend_q;
  logic             gen_ack_q;
  logic [7:0]       drop_cnt_q;
  logic [SLOTS-1:0] valid_q;
  logic [TYPEW-1:0] type_q [SLOTS];
  logic [XW-1:0]    x_q    [SLOTS];
  logic [YW-1:0]    y_q    [SLOTS];
  logic [WW-1:0]    w_q    [SLOTS];
  logic [HW-1:0]    h_q    [SLOTS];

  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic             req_live;

  // Lowest-index free slot wins: iterate downwards so the last hit is the lowest.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign req_live = gen_req && !gen_ack_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      tick_pend_q <= 1'b0;
      gen_ack_q   <= 1'b0;
      drop_cnt_q  <= '0;
      valid_q     <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        type_q[i] <= '0;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        w_q[i]    <= '0;
        h_q[i]    <= '0;
      end
    end else if (clear) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      tick_pend_q <= 1'b0;
      gen_ack_q   <= 1'b0;
      drop_cnt_q  <= '0;
      valid_q     <= '0;
    end else begin
      gen_ack_q <= 1'b0;
      if (tick) tick_pend_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (tick || tick_pend_q) begin
            state_q     <= StScan;
            idx_q       <= '0;
            tick_pend_q <= 1'b0;
          end else if (req_live) begin
            state_q <= StAlloc;
          end
        end
        StScan: begin
          // x < speed despawns, so the subtraction below never wraps.
          if (valid_q[idx_q]) begin
            if (x_q[idx_q] < XW'(speed)) valid_q[idx_q] <= 1'b0;
            else x_q[idx_q] <= x_q[idx_q] - XW'(speed);
          end
          idx_q <= idx_q + IW'(1);
          if (idx_q == IW'(SLOTS - 1)) state_q <= req_live ? StAlloc : StIdle;
        end
        StAlloc: begin
          if (free_found) begin
            type_q[free_idx]  <= gen_type;
            x_q[free_idx]     <= XW'(SCREEN_W);
            y_q[free_idx]     <= gen_y;
            w_q[free_idx]     <= gen_w;
            h_q[free_idx]     <= gen_h;
            valid_q[free_idx] <= 1'b1;
          end else if (drop_cnt_q != 8'hff) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
          end
          gen_ack_q <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    slot_data = '0;
    for (int i = 0; i < SLOTS; i++) begin
      slot_data[i*F +: F] = {type_q[i], x_q[i], y_q[i], w_q[i], h_q[i]};
    end
  end

  assign gen_ack    = gen_ack_q;
  assign busy       = (state_q != StIdle);
  assign slot_valid = valid_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_enemy_slot_scheduler.sv
// Bench for enemy_slot_scheduler: timeline model of scan/alloc scheduling checked every cycle,
// plus directed scenarios with literal expectations.
module tb_enemy_slot_scheduler;
  localparam int SLOTS = 4, TYPEW = 2, XW = 10, YW = 9, WW = 7, HW = 7, SCREEN_W = 640;
  localparam int F = TYPEW + XW + YW + WW + HW;
  localparam int XOFF = YW + WW + HW;

  logic               clock = 1'b0;
  logic               rst = 1'b0;
  logic               clear = 1'b0;
  logic               tick = 1'b0;
  logic [3:0]         speed = 4'd0;
  logic               gen_req = 1'b0;
  logic [TYPEW-1:0]   gen_type = '0;
  logic [YW-1:0]      gen_y = '0;
  logic [WW-1:0]      gen_w = '0;
  logic [HW-1:0]      gen_h = '0;
  logic               gen_ack;
  logic               busy;
  logic [SLOTS-1:0]   slot_valid;
  logic [SLOTS*F-1:0] slot_data;
  logic [7:0]         drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  enemy_slot_scheduler dut (
    .clock(clock), .rst(rst), .clear(clear), .tick(tick), .speed(speed),
    .gen_req(gen_req), .gen_type(gen_type), .gen_y(gen_y), .gen_w(gen_w), .gen_h(gen_h),
    .gen_ack(gen_ack), .busy(busy), .slot_valid(slot_valid), .slot_data(slot_data),
    .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  // Model: a timeline of when scans and allocations happen, derived from the documented latencies.
  logic             m_valid [SLOTS];
  logic [TYPEW-1:0] m_type  [SLOTS];
  logic [XW-1:0]    m_x     [SLOTS];
  logic [YW-1:0]    m_y     [SLOTS];
  logic [WW-1:0]    m_w     [SLOTS];
  logic [HW-1:0]    m_h     [SLOTS];
  int  cyc = 0, free_at = 0, scan_start = -100, alloc_cyc = -100, ack_cyc = -100;
  bit  pend = 0;
  int  m_drop = 0;

  task automatic model_reset();
    for (int i = 0; i < SLOTS; i++) begin
      m_valid[i] = 0; m_type[i] = '0; m_x[i] = '0; m_y[i] = '0; m_w[i] = '0; m_h[i] = '0;
    end
    free_at = 0; scan_start = -100; alloc_cyc = -100; ack_cyc = -100; pend = 0; m_drop = 0;
  endtask

  initial model_reset();
  always @(negedge rst) model_reset();

  always @(posedge clock) begin
    int  cur;
    bit  idle, ackhigh, placed;
    cur = cyc;
    if (rst) begin
      if (clear) begin
        for (int i = 0; i < SLOTS; i++) m_valid[i] = 0;
        pend = 0; m_drop = 0; free_at = cur + 1;
        scan_start = -100; alloc_cyc = -100; ack_cyc = -100;
      end else begin
        ackhigh = (ack_cyc == cur);
        idle = (cur >= free_at);
        if (cur >= scan_start && cur < scan_start + SLOTS) begin
          int k;
          k = cur - scan_start;
          if (m_valid[k]) begin
            if (int'(m_x[k]) < int'(speed)) m_valid[k] = 0;
            else m_x[k] = XW'(int'(m_x[k]) - int'(speed));
          end
          if (k == SLOTS - 1 && gen_req && !ackhigh) begin
            alloc_cyc = cur + 1; free_at = cur + 2;
          end
        end
        if (alloc_cyc == cur) begin
          placed = 0;
          for (int i = 0; i < SLOTS; i++) begin
            if (!placed && !m_valid[i]) begin
              placed = 1; m_valid[i] = 1; m_type[i] = gen_type; m_x[i] = XW'(SCREEN_W);
              m_y[i] = gen_y; m_w[i] = gen_w; m_h[i] = gen_h;
            end
          end
          if (!placed && m_drop < 255) m_drop++;
          ack_cyc = cur + 1;
        end
        if (idle && (tick || pend)) begin
          scan_start = cur + 1; free_at = cur + 1 + SLOTS; pend = 0;
        end else if (idle && gen_req && !ackhigh) begin
          alloc_cyc = cur + 1; free_at = cur + 2;
        end else if (tick) begin
          pend = 1;
        end
      end
    end
    cyc = cur + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Per-cycle compare against the model; data only matters for live slots.
  always @(negedge clock) begin
    if (rst) begin
      logic [SLOTS-1:0] ev;
      for (int i = 0; i < SLOTS; i++) ev[i] = m_valid[i];
      chk("cyc slot_valid", 32'(slot_valid), 32'(ev));
      chk("cyc busy", 32'(busy), 32'(!(cyc >= free_at)));
      chk("cyc gen_ack", 32'(gen_ack), 32'(ack_cyc == cyc));
      chk("cyc drop_cnt", 32'(drop_cnt), 32'(m_drop));
      for (int i = 0; i < SLOTS; i++) begin
        if (m_valid[i]) begin
          logic [F-1:0] e;
          e = {m_type[i], m_x[i], m_y[i], m_w[i], m_h[i]};
          chk($sformatf("cyc slot%0d data", i), 32'(slot_data[i*F +: F]), 32'(e));
        end
      end
    end
  end

  function automatic logic [31:0] xof(input int i);
    logic [SLOTS*F-1:0] d;
    d = slot_data;
    return 32'(d[i*F + XOFF +: XW]);
  endfunction

  task automatic request(input int t, input int y, input int w, input int h, output int lat);
    @(negedge clock);
    gen_req = 1; gen_type = TYPEW'(t); gen_y = YW'(y); gen_w = WW'(w); gen_h = HW'(h);
    lat = -1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      if (gen_ack) begin lat = k; break; end
    end
    gen_req = 0;
    if (lat < 0) chk("request timeout", 32'd0, 32'd1);
  endtask

  task automatic tick_once(output int busy_cycles);
    @(negedge clock);
    tick = 1;
    @(negedge clock);
    tick = 0;
    busy_cycles = 0;
    for (int k = 0; k < 100; k++) begin
      if (!busy) break;
      busy_cycles++;
      @(negedge clock);
    end
    if (busy) chk("scan timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int lat, bc;
    repeat (3) @(negedge clock);
    rst = 1;
    @(negedge clock);
    chk("reset slot_valid", 32'(slot_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset drop_cnt", 32'(drop_cnt), 32'd0);

    // Spawn into empty table
    request(2, 300, 20, 40, lat);
    chk("spawn latency", 32'(lat), 32'd2);
    chk("spawn valid", 32'(slot_valid), 32'b0001);
    chk("spawn slot0", 32'(slot_data[0 +: F]), 32'({2'd2, 10'd640, 9'd300, 7'd20, 7'd40}));

    // Scroll
    speed = 4'd5;
    tick_once(bc);
    chk("scroll busy cycles", 32'(bc), 32'd4);
    chk("scroll slot0 x", xof(0), 32'd635);

    // Walk slot0 down to x=3 (635 - 79*8)
    speed = 4'd8;
    for (int n = 0; n < 79; n++) tick_once(bc);
    chk("walk slot0 x", xof(0), 32'd3);
    request(1, 100, 10, 12, lat);
    chk("second fills slot1", 32'(slot_valid), 32'b0011);

    // Despawn and reuse
    speed = 4'd5;
    tick_once(bc);
    chk("despawn valid", 32'(slot_valid), 32'b0010);
    chk("slot1 scrolled", xof(1), 32'd635);
    request(3, 50, 5, 6, lat);
    chk("reuse valid", 32'(slot_valid), 32'b0011);
    chk("reuse slot0 x", xof(0), 32'd640);

    // Full table
    request(0, 10, 1, 1, lat);
    request(1, 20, 2, 2, lat);
    chk("full valid", 32'(slot_valid), 32'b1111);
    request(2, 30, 3, 3, lat);
    chk("drop ack latency", 32'(lat), 32'd2);
    chk("drop_cnt first", 32'(drop_cnt), 32'd1);
    chk("drop keeps slots", 32'(slot_valid), 32'b1111);
    for (int n = 0; n < 299; n++) request(2, 30, 3, 3, lat);
    chk("drop_cnt saturated", 32'(drop_cnt), 32'd255);

    // Clear
    @(negedge clock); clear = 1;
    @(negedge clock); clear = 0;
    chk("clear valid", 32'(slot_valid), 32'd0);
    chk("clear drop_cnt", 32'(drop_cnt), 32'd0);

    // tick and gen_req together; another tick lands during the ALLOC cycle
    @(negedge clock);
    tick = 1; gen_req = 1; gen_type = 2'd1; gen_y = 9'd77; gen_w = 7'd9; gen_h = 7'd8;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 1) tick = 0;
      if (k == 6) tick = 0;
      if (gen_ack) begin lat = k; break; end
      if (k == 5) tick = 1;
    end
    gen_req = 0; tick = 0;
    chk("tick+req latency", 32'(lat), 32'd6);
    chk("tick+req slot0 x", xof(0), 32'd640);
    bc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (busy) bc++;
      else if (bc > 0) break;
    end
    chk("pending scan cycles", 32'(bc), 32'd4);
    chk("pending scan x", xof(0), 32'd635);
    bc = 0;
    repeat (8) begin @(negedge clock); if (busy) bc++; end
    chk("no extra scan", 32'(bc), 32'd0);

    // Reset mid-scan
    @(negedge clock); tick = 1;
    @(negedge clock); tick = 0;
    @(negedge clock);
    rst = 0;
    #1;
    chk("midscan reset valid", 32'(slot_valid), 32'd0);
    chk("midscan reset busy", 32'(busy), 32'd0);
    chk("midscan reset ack", 32'(gen_ack), 32'd0);
    chk("midscan reset drop", 32'(drop_cnt), 32'd0);
    chk("midscan reset data", 32'(slot_data[0 +: F]), 32'd0);
    @(negedge clock); rst = 1;
    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
